// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4 write-channel slave.
package axi_pkg;

    // Write-path FSM states; the encoding is exported on state_w_out for debug.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    // AXI burst types (awburst)
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // AXI write responses (bresp)
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only 2-byte beats match the 16-bit local word.
    localparam logic [2:0] SIZE_16B = 3'b001;

    // A burst is unsupported when it wraps, uses the reserved burst code,
    // or moves anything other than one 16-bit word per beat.
    function automatic logic burst_unsupported(input logic [1:0] burst,
                                               input logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size != SIZE_16B);
    endfunction

endpackage

// File: rtl/axi.sv
// AXI4 write-channel slave: turns AW/W/B traffic into single-cycle writes
// on a 16-bit local register/memory port. Read channels are not handled.
module axi
    import axi_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64
) (
    input  logic                    a_clk,
    input  logic                    a_rst_n,
    // write address channel
    input  logic                    awvalid,
    input  logic [AXI_ADDR_W-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    output logic                    awready,
    // write data channel
    input  logic                    wvalid,
    input  logic [AXI_DATA_W-1:0]   wdata,
    input  logic [AXI_DATA_W/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    wready,
    // write response channel
    output logic                    bvalid,
    output logic [1:0]              bresp,
    input  logic                    bready,
    // local write port
    output logic [ADDR_W-1:0]       a_address_wr,
    output logic [DATA_W-1:0]       a_data_out,
    output logic                    a_wr,
    // debug
    output logic [1:0]              state_w_out
);

    state_t             state;
    state_t             state_nxt;

    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         len_q;
    logic [1:0]         burst_q;
    logic [2:0]         size_q;
    logic [3:0]         beat_cnt;
    logic               err_q;

    logic               aw_fire;
    logic               w_fire;
    logic               cnt_last;
    logic               burst_end;
    logic               len_mismatch;
    logic [ADDR_W-1:0]  beat_addr;

    // Upper address/data bits, strobes and the latched size have no effect
    // on the 16-bit local port; folding them here keeps them visibly consumed.
    logic               unused_inputs;
    assign unused_inputs = ^{awaddr[AXI_ADDR_W-1:ADDR_W], wdata[AXI_DATA_W-1:DATA_W],
                             wstrb, size_q};

    // Handshakes are decoded from the registered state. awready is also held
    // low while reset is asserted so the master never sees an accept then.
    assign awready     = (state == IDLE) && a_rst_n;
    assign wready      = (state == DATA);
    assign bvalid      = (state == RESP);
    assign bresp       = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign state_w_out = state;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    // The burst closes on wlast or on the final counted beat, whichever comes
    // first; when they disagree the transaction is reported as SLVERR.
    assign cnt_last     = (beat_cnt == len_q);
    assign burst_end    = wlast || cnt_last;
    assign len_mismatch = (wlast != cnt_last);

    // FIXED keeps hitting the start word; INCR steps one word per beat and
    // wraps naturally at the top of the local address space.
    assign beat_addr = (burst_q == BURST_FIXED) ? addr_q
                                                : addr_q + ADDR_W'(beat_cnt);

    // State register
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; any unknown code falls back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_fire) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_fire && burst_end) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst context: captured on address accept, beat count and error
    // flag updated as data beats arrive
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            size_q   <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else if (aw_fire) begin
            addr_q   <= awaddr[ADDR_W-1:0];
            len_q    <= awlen;
            burst_q  <= awburst;
            size_q   <= awsize;
            beat_cnt <= '0;
            err_q    <= burst_unsupported(awburst, awsize);
        end else if (w_fire) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (burst_end && len_mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    // Local write port: one registered strobe per accepted beat; address
    // and data hold their last values between writes. Beats of a burst
    // already flagged as bad are dropped.
    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            a_wr         <= 1'b0;
            a_address_wr <= '0;
            a_data_out   <= '0;
        end else begin
            a_wr <= 1'b0;
            if (w_fire && !err_q) begin
                a_wr         <= 1'b1;
                a_address_wr <= beat_addr;
                a_data_out   <= wdata[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_axi.sv
// Scoreboard bench for the AXI write-channel slave: stimulus pushes the
// expected local writes and responses, a negedge monitor pops and compares.
module tb_axi;

    logic        a_clk = 1'b0;
    logic        a_rst_n;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awready;
    logic        wvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic [12:0] a_address_wr;
    logic [15:0] a_data_out;
    logic        a_wr;
    logic [1:0]  state_w_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [1:0] exp_resp[$];
    wr_t        mon_w;
    logic [1:0] mon_r;

    always #5 a_clk = ~a_clk;

    axi dut (
        .a_clk        (a_clk),
        .a_rst_n      (a_rst_n),
        .awvalid      (awvalid),
        .awaddr       (awaddr),
        .awlen        (awlen),
        .awsize       (awsize),
        .awburst      (awburst),
        .awready      (awready),
        .wvalid       (wvalid),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .wready       (wready),
        .bvalid       (bvalid),
        .bresp        (bresp),
        .bready       (bready),
        .a_address_wr (a_address_wr),
        .a_data_out   (a_data_out),
        .a_wr         (a_wr),
        .state_w_out  (state_w_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every local write and every accepted response must match the
    // head of its scoreboard queue.
    always @(negedge a_clk) begin
        if (a_wr === 1'b1) begin
            if (exp_wr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got write to 0x%0h, expected none", a_address_wr);
            end else begin
                mon_w = exp_wr.pop_front();
                check("wr_addr", {19'd0, a_address_wr}, {19'd0, mon_w.addr});
                check("wr_data", {16'd0, a_data_out}, {16'd0, mon_w.data});
            end
        end
        if (bvalid === 1'b1 && bready === 1'b1) begin
            if (exp_resp.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got bresp 0x%0h, expected no response", bresp);
            end else begin
                mon_r = exp_resp.pop_front();
                check("bresp", {30'd0, bresp}, {30'd0, mon_r});
            end
        end
    end

    // One full AW/W/B transaction.
    // wlast_pos: beat index carrying wlast (-1 = never asserted).
    // gap: idle cycles between beats (-1 = random 0..2).
    // bdelay: cycles bready stays low after bvalid rises.
    // aw_in_resp: offer a new address while waiting in the response phase.
    task automatic do_burst(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_pos, input int gap, input int bdelay,
                            input logic [15:0] d0, input logic [15:0] d1,
                            input bit aw_in_resp);
        logic [63:0] wd [16];
        int          endi;
        int          nb;
        int          n;
        int          g;
        bit          err;
        wr_t         w;

        // Reference: the burst stops at wlast or after len+1 beats; writes
        // happen only while no error has been detected yet.
        endi = int'(len);
        if (wlast_pos >= 0 && wlast_pos < int'(len)) endi = wlast_pos;
        nb = endi + 1;
        for (int i = 0; i < 16; i++) wd[i] = {$urandom, $urandom};
        wd[0][15:0] = d0;
        wd[1][15:0] = d1;
        err = (burst >= 2'd2) || (size != 3'd1);
        for (int i = 0; i < nb; i++) begin
            if (!err) begin
                if (burst == 2'b00) w.addr = 13'(int'(addr % 32'd8192));
                else                w.addr = 13'((int'(addr % 32'd8192) + i) % 8192);
                w.data = wd[i][15:0];
                exp_wr.push_back(w);
            end
            if (i == endi && ((i == wlast_pos) != (i == int'(len)))) err = 1'b1;
        end
        exp_resp.push_back(err ? 2'b10 : 2'b00);

        // Address phase
        @(posedge a_clk); #1;
        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = len;
        awsize  = size;
        awburst = burst;
        n = 0;
        do begin @(negedge a_clk); n++; end while (awready !== 1'b1 && n < 50);
        check("aw_accept", {31'd0, awready}, 32'd1);
        @(posedge a_clk); #1;
        awvalid = 1'b0;
        awaddr  = $urandom;
        @(negedge a_clk);
        check("state_data", {30'd0, state_w_out}, 32'd1);

        // Data phase
        for (int i = 0; i < nb; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
            repeat (g) begin
                @(posedge a_clk); #1;
                wvalid = 1'b0;
                @(negedge a_clk);
                check("wready_gap", {31'd0, wready}, 32'd1);
            end
            @(posedge a_clk); #1;
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = 8'($urandom);
            wlast  = (i == wlast_pos);
            n = 0;
            do begin @(negedge a_clk); n++; end while (wready !== 1'b1 && n < 50);
            check("w_accept", {31'd0, wready}, 32'd1);
        end
        @(posedge a_clk); #1;
        wvalid = 1'b0;
        wlast  = 1'b0;

        // Response phase
        if (bdelay > 0) begin
            n = 0;
            do begin @(negedge a_clk); n++; end while (bvalid !== 1'b1 && n < 50);
            check("bvalid_rise", {31'd0, bvalid}, 32'd1);
            awvalid = aw_in_resp;
            repeat (bdelay) begin
                @(posedge a_clk); #1;
                @(negedge a_clk);
                check("bvalid_hold", {31'd0, bvalid}, 32'd1);
                check("aw_blocked", {31'd0, awready}, 32'd0);
            end
            @(posedge a_clk); #1;
            awvalid = 1'b0;
        end
        bready = 1'b1;
        n = 0;
        do begin @(negedge a_clk); n++; end while (bvalid !== 1'b1 && n < 50);
        check("b_accept", {31'd0, bvalid}, 32'd1);
        @(posedge a_clk); #1;
        bready = 1'b0;
        @(negedge a_clk);
        check("state_idle", {30'd0, state_w_out}, 32'd0);
        check("awready_idle", {31'd0, awready}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, {31'd0, awready}, 32'd0);
        check({tag, "_wready"},  {31'd0, wready},  32'd0);
        check({tag, "_bvalid"},  {31'd0, bvalid},  32'd0);
        check({tag, "_bresp"},   {30'd0, bresp},   32'd0);
        check({tag, "_a_wr"},    {31'd0, a_wr},    32'd0);
        check({tag, "_addr"},    {19'd0, a_address_wr}, 32'd0);
        check({tag, "_data"},    {16'd0, a_data_out},   32'd0);
        check({tag, "_state"},   {30'd0, state_w_out},  32'd0);
    endtask

    initial begin
        int          n;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          wp;
        int          r;
        logic [31:0] addr;

        a_rst_n = 1'b0;
        awvalid = 1'b0;
        awaddr  = '0;
        awlen   = '0;
        awsize  = '0;
        awburst = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        bready  = 1'b0;

        // Reset held for two cycles
        repeat (2) @(posedge a_clk);
        @(negedge a_clk);
        check_all_zero("rst");
        @(posedge a_clk); #1;
        a_rst_n = 1'b1;
        @(negedge a_clk);
        check("rst_release_awready", {31'd0, awready}, 32'd1);
        check("rst_release_state", {30'd0, state_w_out}, 32'd0);

        // INCR 2-beat, bready two cycles late
        do_burst(32'h0000_000A, 4'd1, 3'd1, 2'b01, 1, 0, 2, 16'hABCD, 16'hBBDD, 1'b0);
        // FIXED single beat at 0x1000
        do_burst(32'h0000_1000, 4'd0, 3'd1, 2'b00, 0, 0, 0, 16'hABCD, 16'h0000, 1'b0);
        // INCR 3 beats with two idle cycles between beats
        do_burst(32'h0000_0100, 4'd2, 3'd1, 2'b01, 2, 2, 1, 16'h1111, 16'h2222, 1'b0);
        // WRAP burst: no writes, SLVERR
        do_burst(32'h0000_0040, 4'd0, 3'd1, 2'b10, 0, 0, 0, 16'h5A5A, 16'h0000, 1'b0);
        // Early wlast on beat 0 of a 2-beat burst: one write, SLVERR
        do_burst(32'h0000_0200, 4'd1, 3'd1, 2'b01, 0, 0, 0, 16'hC0DE, 16'h0000, 1'b0);
        // Missing wlast: burst closes on the counted beat, SLVERR
        do_burst(32'h0000_0300, 4'd2, 3'd1, 2'b01, -1, 0, 0, 16'h0F0F, 16'hF0F0, 1'b0);
        // Wrong beat size: SLVERR, nothing written
        do_burst(32'h0000_0400, 4'd1, 3'd2, 2'b01, 1, 0, 0, 16'h7777, 16'h8888, 1'b0);
        // INCR wrapping at the top of the local address space
        do_burst(32'hFFFF_FFFE, 4'd3, 3'd1, 2'b01, 3, 0, 0, 16'h0001, 16'h0002, 1'b0);
        // Response backpressure for 10 cycles while a new address is offered
        do_burst(32'h0000_0500, 4'd0, 3'd1, 2'b01, 0, 0, 10, 16'h9999, 16'h0000, 1'b1);

        // Reset in the middle of DATA: no write and no response follow
        @(posedge a_clk); #1;
        awvalid = 1'b1;
        awaddr  = 32'h0000_0777;
        awlen   = 4'd3;
        awsize  = 3'd1;
        awburst = 2'b01;
        n = 0;
        do begin @(negedge a_clk); n++; end while (awready !== 1'b1 && n < 50);
        check("mid_aw_accept", {31'd0, awready}, 32'd1);
        @(posedge a_clk); #1;
        awvalid = 1'b0;
        @(negedge a_clk);
        check("mid_state_data", {30'd0, state_w_out}, 32'd1);
        a_rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(posedge a_clk); #1;
        a_rst_n = 1'b1;
        // a stray beat in IDLE must not produce a write
        wvalid = 1'b1;
        wdata  = 64'h1234;
        wlast  = 1'b1;
        @(negedge a_clk);
        check("mid_release_state", {30'd0, state_w_out}, 32'd0);
        check("mid_release_awready", {31'd0, awready}, 32'd1);
        check("mid_release_wready", {31'd0, wready}, 32'd0);
        @(posedge a_clk); #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
        repeat (3) @(posedge a_clk);

        // Randomised bursts
        for (int t = 0; t < 40; t++) begin
            len   = 4'($urandom_range(0, 15));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd1;
            burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                                : 2'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)                        wp = int'(len);
            else if (r < 9 && len != 4'd0)    wp = int'($urandom_range(0, int'(len) - 1));
            else                              wp = -1;
            addr = ($urandom_range(0, 3) == 0) ? (32'h1FF8 + 32'($urandom_range(0, 7))) : $urandom;
            do_burst(addr, len, size, burst, wp, -1, int'($urandom_range(0, 3)),
                     16'($urandom), 16'($urandom), 1'($urandom));
        end

        repeat (5) @(posedge a_clk);
        @(negedge a_clk);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        check("resps_drained", 32'(exp_resp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi.md
Name: axi

Overview:
- AXI4 write-channel slave. It bridges an AXI master's AW/W/B channels onto a simple 16-bit register/memory write port (a_address_wr / a_data_out / a_wr).
- Sits between the bus interconnect and the FIR block's coefficient/sample storage.
- Read channels are out of scope.
- A 2-bit state code is exported for debug.

Parameters:
- ADDR_W, 13, width of a_address_wr (local address space)
- DATA_W, 16, width of a_data_out (local word size)
- AXI_ADDR_W, 32, width of awaddr
- AXI_DATA_W, 64, width of wdata; wstrb is AXI_DATA_W/8

Ports:
- a_clk in 1: clock, rising edge
- a_rst_n in 1: asynchronous active-low reset
- awvalid in 1: write address valid
- awaddr in 32: burst start address; local word address = awaddr[ADDR_W-1:0]
- awlen in 4: beats minus 1
- awsize in 3: bytes per beat, log2
- awburst in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awready out 1: address accepted
- wvalid in 1: write data valid
- wdata in 64: write data; only [15:0] used
- wstrb in 8: byte strobes; ignored
- wlast in 1: last beat of burst
- wready out 1: data accepted
- bvalid out 1: write response valid
- bresp out 2: 00 OKAY, 10 SLVERR
- bready in 1: master accepts response
- a_address_wr out 13: local write address
- a_data_out out 16: local write data
- a_wr out 1: local write strobe, one cycle per beat
- state_w_out out 2: current FSM state code

Behaviour:
- Reset (async, a_rst_n=0):
  - state=IDLE; awready=0, wready=0, bvalid=0, bresp=00, a_wr=0.
  - a_address_wr=0, a_data_out=0, beat counter=0, error flag=0.
- FSM states (state_w_out): IDLE=2'd0, DATA=2'd1, RESP=2'd2. Code 3 is illegal and goes to IDLE next cycle.
- Ready/valid outputs are decoded from registered state:
  - awready = (state==IDLE)
  - wready = (state==DATA)
  - bvalid = (state==RESP)
- IDLE: on awvalid&&awready at a clock edge:
  - latch addr = awaddr[12:0], len = awlen, burst, size.
  - beat counter := 0; go to DATA.
  - error := (awburst is WRAP or reserved) || (awsize != 3'b001).
- DATA:
  - On each wvalid&&wready edge, a_wr=1 for exactly the following cycle, with a_address_wr = current beat address and a_data_out = wdata[15:0] (registered; 1-cycle latency). If error=1, a_wr stays 0 and the data is discarded.
  - Beat address: INCR → latched addr + beat index, wrapping modulo 2^13. FIXED → latched addr for every beat.
  - The burst ends on the beat where wlast=1 OR beat counter==len, whichever comes first. If the two do not coincide, error := 1 (SLVERR), but beats already written stay written. Then go to RESP.
  - wvalid=0 holds the state; the counter does not advance.
- RESP:
  - bresp = error ? 2'b10 : 2'b00.
  - Stay until bready=1 at an edge, then go to IDLE (awready high the next cycle).
  - bvalid is never dropped before bready.
- Minimum burst timing: AW accept at cycle N; W beats at N+1 … N+1+len; RESP from the cycle after the last beat.
- a_address_wr/a_data_out hold their last values when a_wr=0.
- Single outstanding transaction: no AW acceptance while in DATA/RESP.
- Reset mid-burst aborts immediately with no response; the next cycle after release is IDLE.

Decomposition:
- Package axi_pkg:
  - state enum {IDLE, DATA, RESP} (2-bit)
  - burst constants BURST_FIXED/INCR/WRAP
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - SIZE_16B=3'b001
- Single module; no sub-module needed.

Test Plan:
- Reset: hold a_rst_n=0 for 2 cycles → all outputs 0, state_w_out=0; after release awready=1.
- INCR 2-beat: awaddr=0x0A, awlen=1, awsize=1, awburst=01 for 1 cycle; then wdata 0xABCD, then 0xBBDD with wlast=1; bready raised 2 cycles later → a_wr pulses with (0x00A,0xABCD) then (0x00B,0xBBDD). bvalid=1 with bresp=00 is held until bready; state sequence 0→1→1→2→…→0.
- FIXED single beat: awaddr=0x1000, awlen=0, awburst=00, wdata=0xABCD, wlast=1 → one a_wr at address 0x1000, data 0xABCD; bresp=00.
- wvalid gaps: INCR awlen=2 with wvalid low for 2 cycles between beats → three a_wr pulses at addr, addr+1, addr+2 only; wready stays 1 throughout DATA.
- Error: awburst=10 (WRAP), awlen=0 → a_wr never asserts; bresp=10. Separately, early wlast on beat 0 with awlen=1 → one write performed, bresp=10.
- Backpressure/reset: bready held 0 for 10 cycles → bvalid stays 1 and awvalid is not accepted; asserting a_rst_n=0 mid-DATA → immediate IDLE, no bvalid.
